// File: rtl/gate_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// gate_pattern_gen_if
// Valid/ready pattern channel between the stimulus generator and the
// capture/compare stage that drives the gate-model netlist.
//   pat_valid  master->slave  pat_data/pat_index hold a vector
//   pat_ready  slave->master  downstream accepts the vector
//   pat_data   master->slave  WIDTH-bit input vector (bit k drives N(k+1))
//   pat_index  master->slave  0-based index of the vector within the run
// ---------------------------------------------------------------------------
interface gate_pattern_gen_if #(
    parameter int WIDTH = 23,
    parameter int CNT_W = 16
);
    logic             pat_valid;
    logic             pat_ready;
    logic [WIDTH-1:0] pat_data;
    logic [CNT_W-1:0] pat_index;

    modport master (
        output pat_valid,
        output pat_data,
        output pat_index,
        input  pat_ready
    );

    modport slave (
        input  pat_valid,
        input  pat_data,
        input  pat_index,
        output pat_ready
    );
endinterface

// File: rtl/gate_pattern_gen.sv
// ---------------------------------------------------------------------------
// gate_pattern_gen
// Produces a programmable-length run of WIDTH-bit input vectors from a
// Fibonacci LFSR (x^23+x^18+1 by default) and hands them downstream over a
// valid/ready channel. Reports busy while running and a one-cycle done pulse
// at the end of each run.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   start         start-run pulse, honoured only in IDLE
//   num_patterns  run length, latched on an accepted start
//   seed_load     load seed_in into the seed register, honoured only in IDLE
//   seed_in       new seed (zero is replaced by SEED)
//   pat           master side of gate_pattern_gen_if (valid/ready/data/index)
//   busy          high while vectors are being issued
//   done          single-cycle pulse after the last vector is accepted
//
// Build option: define GATE_PATGEN_WALK_EN to prefix every run with a
// walking-zero preamble (all-ones with bit k cleared, k = 0..WIDTH-1).
// ---------------------------------------------------------------------------
module gate_pattern_gen #(
    parameter int               WIDTH = 23,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] SEED  = 23'h000001,
    parameter logic [WIDTH-1:0] TAPS  = 23'h420000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_patterns,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    gate_pattern_gen_if.master  pat,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [WIDTH-1:0] seed_eff;
    logic [WIDTH-1:0] pat_data_r;
    logic [CNT_W-1:0] pat_index_r;
    logic [CNT_W-1:0] len;
    logic             valid_w;
    logic             hs;
    logic             last;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

`ifdef GATE_PATGEN_WALK_EN
    function automatic logic [WIDTH-1:0] walk_vec(input int k);
        return ~({{(WIDTH-1){1'b0}}, 1'b1} << k);
    endfunction

    logic [31:0] idx_wide;
    assign idx_wide = 32'(pat_index_r);
`endif

    // A same-cycle seed_load is applied before start so the run sees it.
    assign seed_eff = !seed_load      ? seed_reg :
                      (seed_in == '0) ? SEED     : seed_in;
    assign lfsr_nxt = lfsr_step(lfsr);
    assign hs       = valid_w & pat.pat_ready;
    assign last     = (pat_index_r == len - CNT_W'(1));

    assign pat.pat_valid = valid_w;
    assign pat.pat_data  = pat_data_r;
    assign pat.pat_index = pat_index_r;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        valid_w   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = (num_patterns != '0) ? RUN : FIN;
            end
            RUN: begin
                valid_w = 1'b1;
                busy    = 1'b1;
                if (hs && last) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seed_reg    <= SEED;
            lfsr        <= SEED;
            pat_data_r  <= '0;
            pat_index_r <= '0;
            len         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (seed_load) seed_reg <= seed_eff;
                    if (start && num_patterns != '0) begin
                        len         <= num_patterns;
                        pat_index_r <= '0;
                        lfsr        <= seed_eff;
`ifdef GATE_PATGEN_WALK_EN
                        pat_data_r  <= walk_vec(0);
`else
                        pat_data_r  <= seed_eff;
`endif
                    end
                end
                RUN: begin
                    if (hs && !last) begin
                        pat_index_r <= pat_index_r + CNT_W'(1);
`ifdef GATE_PATGEN_WALK_EN
                        // lfsr holds the seed untouched through the preamble,
                        // so the first LFSR vector is the seed itself.
                        if (idx_wide < 32'(WIDTH - 1)) begin
                            pat_data_r <= walk_vec(int'(idx_wide) + 1);
                        end else if (idx_wide == 32'(WIDTH - 1)) begin
                            pat_data_r <= lfsr;
                        end else begin
                            lfsr       <= lfsr_nxt;
                            pat_data_r <= lfsr_nxt;
                        end
`else
                        lfsr       <= lfsr_nxt;
                        pat_data_r <= lfsr_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/gate_pattern_gen.md
Name: gate_pattern_gen

Overview:
- Upstream stimulus stage for the combinational gate-model netlists (23 primary inputs N1..N23).
- Produces a programmable-length sequence of 23-bit input vectors from a Fibonacci LFSR.
- Delivers the vectors over a valid/ready handshake to the capture/compare stage that drives and samples the gate model.
- Reports busy/done status to the lab sequencer.

Parameters:
- WIDTH, 23, vector width; bit k drives input N(k+1).
- CNT_W, 16, width of the pattern counter and length register.
- SEED, 23'h000001, reset and fallback seed; must be non-zero.
- TAPS, 23'h420000, feedback mask for x^23+x^18+1 (bits 22 and 17).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  start-run pulse; sampled only in IDLE.
- num_patterns  in  CNT_W  run length; latched on an accepted start.
- seed_load  in  1  loads seed_in into the seed register; honoured only in IDLE.
- seed_in  in  WIDTH  new seed value.
- pat_valid  out  1  pat_data holds a vector.
- pat_ready  in  1  downstream accepts the vector.
- pat_data  out  WIDTH  current vector.
- pat_index  out  CNT_W  index of the current vector, 0-based.
- busy  out  1  high in RUN.
- done  out  1  single-cycle pulse at the end of a run.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low.
- Reset values (rst_n low at a clock edge): state=IDLE, seed_reg=SEED, lfsr=SEED, pat_valid=0, pat_data=0, pat_index=0, busy=0, done=0. A reset mid-run aborts the run with no done pulse.
- LFSR step:
  - fb = XOR-reduce(lfsr & TAPS)
  - next = {lfsr[WIDTH-2:0], fb}
  - Advances only on a handshake (pat_valid & pat_ready).
- States: IDLE, RUN, FIN.
- IDLE:
  - seed_load=1: seed_reg <= (seed_in==0 ? SEED : seed_in). Zero is replaced to avoid LFSR lock-up.
  - start=1 with num_patterns != 0: latch len=num_patterns, lfsr<=seed_reg, pat_index<=0, go to RUN. pat_valid rises the next cycle.
  - start=1 with num_patterns == 0: go to FIN. No vector is issued.
  - start and seed_load in the same cycle: the seed load takes effect first, so the run uses the new seed.
- RUN:
  - busy=1, pat_valid=1, pat_data=lfsr (registered; 1-cycle latency from start to the first vector).
  - pat_data and pat_index stay stable while pat_valid=1 and pat_ready=0. No bubble between consecutive vectors while ready is held high.
  - On a handshake with pat_index != len-1: advance lfsr, increment pat_index.
  - On a handshake with pat_index == len-1: pat_valid<=0, go to FIN.
  - start and seed_load are ignored in RUN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. pat_data keeps its last value. pat_index keeps its last value until the next start.
- len=2^CNT_W-1 is the maximum. A run longer than 2^WIDTH-1 vectors repeats the sequence; this is legal.

Optional Feature:
- Macro: GATE_PATGEN_WALK_EN.
- When defined:
  - Each run begins with a walking-zero preamble: vector k (k=0..WIDTH-1) = all-ones with bit k cleared.
  - The preamble counts toward num_patterns and pat_index.
  - After the preamble, the LFSR sequence starts from seed_reg.
  - If len <= WIDTH, only the first len preamble vectors are issued.
- When undefined: pure LFSR sequence; the preamble logic is absent.

Test Plan:
- Reset, then start with num_patterns=20, pat_ready=1 constantly -> pat_data sequence: 1<<k for k=0..17, then 0x020000 at index 17, 0x040001 at index 18, 0x080002 at index 19; done pulse 1 cycle after the last handshake; busy low after that.
- Run with num_patterns=4, pat_ready toggled 1/0 each cycle -> each vector held stable while ready=0; exactly 4 handshakes; pat_index 0,1,2,3.
- seed_load with seed_in=0 in IDLE, then a run of 1 -> pat_data=0x000001. seed_load with 0x7FFFFF, run of 2 -> 0x7FFFFF, then 0x7FFFFE.
- start with num_patterns=0 -> pat_valid never asserts; done=1 the cycle after start.
- Mid-run (index 5, num_patterns=10): start and seed_load asserted -> ignored; rst_n low for one edge -> pat_valid=0, busy=0, no done, seed_reg=SEED.
- With GATE_PATGEN_WALK_EN defined, num_patterns=25 -> 0x7FFFFE, 0x7FFFFD, ... 0x3FFFFF, then 0x000001, 0x000002.
